// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state types and the drop-list helper for the
// PS/2 keyboard event controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    // Keyboard status / protocol bytes that never form part of a key event
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ACK,
        F_GAP
    } fetch_state_t;

    typedef enum logic [1:0] {
        P_BASE,
        P_EXT,
        P_BRK,
        P_EXTBRK
    } parse_state_t;

    // True for bytes silently discarded when no prefix is pending
    function automatic logic is_drop(input logic [7:0] b);
        return (b == SC_PAUSE)  || (b == SC_BAT_OK) || (b == SC_ACK) ||
               (b == SC_ECHO)   || (b == SC_ERR_LO) || (b == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_byte_fetch.sv
// Pops one byte at a time from the PS/2 receiver FIFO. A byte is handed to the
// parser on the edge it is accepted; the pop strobe follows for one cycle and a
// gap cycle lets the receiver's ready flag settle before the next fetch.
module ps2_byte_fetch
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic       byte_vld,
    output logic [7:0] byte_data
);

    fetch_state_t state;

    // Byte is consumed by the parser on the same edge the fetch FSM leaves F_IDLE
    assign byte_vld  = (state == F_IDLE) && ready;
    assign byte_data = data;

    // Fetch FSM with registered pop strobe
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= F_IDLE;
            nextdata_n <= 1'b1;
        end else begin
            case (state)
                F_IDLE: begin
                    if (ready) begin
                        state      <= F_ACK;
                        nextdata_n <= 1'b0;
                    end
                end
                F_ACK: begin
                    state      <= F_GAP;
                    nextdata_n <= 1'b1;
                end
                F_GAP: begin
                    state <= F_IDLE;
                end
                default: begin
                    state      <= F_IDLE;
                    nextdata_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Keyboard event controller: parses make/break/extended scan-code sequences into
// single key events, tracks the held key, filters typematic repeats out of the
// press count and latches receiver overflow.
module ps2_key_ctrl #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_break,
    output logic               key_repeat,
    output logic               held,
    output logic [7:0]         held_code,
    output logic               held_ext,
    output logic [COUNT_W-1:0] press_count,
    output logic               ovf_err
);
    import ps2_pkg::*;

    logic         byte_vld;
    logic [7:0]   byte_data;
    parse_state_t pstate;
    parse_state_t pstate_nxt;
    logic         ev_fire;
    logic         ev_brk;
    logic         ev_ext;
    logic         ev_match;

    ps2_byte_fetch u_fetch (
        .clk       (clk),
        .clrn      (clrn),
        .ready     (ready),
        .data      (data),
        .nextdata_n(nextdata_n),
        .byte_vld  (byte_vld),
        .byte_data (byte_data)
    );

    // Event pair compared against the held key as (code, ext)
    assign ev_match = (byte_data == held_code) && (ev_ext == held_ext);

    // Decode the incoming byte into a prefix transition or a key event
    always_comb begin
        pstate_nxt = pstate;
        ev_fire    = 1'b0;
        ev_brk     = 1'b0;
        ev_ext     = 1'b0;
        if (byte_vld) begin
            unique case (pstate)
                P_BASE: begin
                    if (byte_data == SC_EXT) begin
                        pstate_nxt = P_EXT;
                    end else if (byte_data == SC_BRK) begin
                        pstate_nxt = P_BRK;
                    end else if (!is_drop(byte_data)) begin
                        ev_fire = 1'b1;
                    end
                end
                P_EXT: begin
                    if (byte_data == SC_BRK) begin
                        pstate_nxt = P_EXTBRK;
                    end else if (byte_data != SC_EXT) begin
                        ev_fire    = 1'b1;
                        ev_ext     = 1'b1;
                        pstate_nxt = P_BASE;
                    end
                end
                P_BRK: begin
                    ev_fire    = 1'b1;
                    ev_brk     = 1'b1;
                    pstate_nxt = P_BASE;
                end
                P_EXTBRK: begin
                    ev_fire    = 1'b1;
                    ev_brk     = 1'b1;
                    ev_ext     = 1'b1;
                    pstate_nxt = P_BASE;
                end
            endcase
        end
    end

    // Parse state, event outputs, held-key tracking and sticky overflow
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pstate      <= P_BASE;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_repeat  <= 1'b0;
            held        <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_count <= '0;
            ovf_err     <= 1'b0;
        end else begin
            pstate    <= pstate_nxt;
            key_valid <= ev_fire;
            if (overflow) begin
                ovf_err <= 1'b1;
            end
            if (ev_fire) begin
                key_code   <= byte_data;
                key_ext    <= ev_ext;
                key_break  <= ev_brk;
                key_repeat <= !ev_brk && held && ev_match;
                if (!ev_brk) begin
                    // Single-key rollover: any make that is not a repeat becomes the held key
                    if (!(held && ev_match)) begin
                        press_count <= press_count + COUNT_W'(1);
                        held        <= 1'b1;
                        held_code   <= byte_data;
                        held_ext    <= ev_ext;
                    end
                end else if (ev_match) begin
                    held <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: a queue emulates the receiver FIFO, a
// byte-stream model predicts every output each cycle, and directed sequences
// carry hand-computed expectations.
module tb_ps2_key_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          ready = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          overflow = 1'b0;
    logic          nextdata_n;
    logic          key_valid;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_break;
    logic          key_repeat;
    logic          held;
    logic [7:0]    held_code;
    logic          held_ext;
    logic [CW-1:0] press_count;
    logic          ovf_err;

    ps2_key_ctrl #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_repeat (key_repeat),
        .held       (held),
        .held_code  (held_code),
        .held_ext   (held_ext),
        .press_count(press_count),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Receiver FIFO emulation
    logic [7:0] fifo[$];

    function automatic void fifo_sync();
        ready = (fifo.size() != 0);
        data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    // Inputs as seen by the DUT at the latest rising edge
    logic       s_clrn = 1'b0;
    logic       s_ready = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ovf = 1'b0;

    always @(posedge clk) begin
        s_clrn  = clrn;
        s_ready = ready;
        s_data  = data;
        s_ovf   = overflow;
    end

    // Reference model: byte stream -> key events, one byte per 3 cycles
    int         m_wait = 0;
    logic       m_nd = 1'b1;
    logic       m_pe = 1'b0;
    logic       m_pb = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_rep = 1'b0;
    logic       m_held = 1'b0;
    logic [7:0] m_hcode = 8'h00;
    logic       m_hext = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic       m_ovf = 1'b0;

    function automatic void model_event(logic [7:0] b, logic e, logic br);
        m_valid = 1'b1;
        m_code  = b;
        m_ext   = e;
        m_brk   = br;
        m_rep   = 1'b0;
        m_pe    = 1'b0;
        m_pb    = 1'b0;
        if (!br) begin
            if (m_held && b == m_hcode && e == m_hext) begin
                m_rep = 1'b1;
            end else begin
                m_cnt   = m_cnt + 1'b1;
                m_held  = 1'b1;
                m_hcode = b;
                m_hext  = e;
            end
        end else if (b == m_hcode && e == m_hext) begin
            m_held = 1'b0;
        end
    endfunction

    function automatic void model_byte(logic [7:0] b);
        if (m_pb) begin
            model_event(b, m_pe, 1'b1);
        end else if (b == 8'hE0) begin
            m_pe = 1'b1;
        end else if (b == 8'hF0) begin
            m_pb = 1'b1;
        end else if (!m_pe && (b == 8'hE1 || b == 8'hAA || b == 8'hFA ||
                               b == 8'hEE || b == 8'h00 || b == 8'hFF)) begin
            m_valid = 1'b0;
        end else begin
            model_event(b, m_pe, 1'b0);
        end
    endfunction

    // Event log of the DUT for literal expectations
    int         n_ev = 0;
    int         n_ack = 0;
    logic [7:0] ev_code[512];
    logic       ev_ext[512];
    logic       ev_brk[512];
    logic       ev_rep[512];
    logic [7:0] ev_hcode[512];
    logic       ev_held[512];
    logic [CW-1:0] ev_cnt[512];

    // Advance the model, compare every output, then act as the receiver
    always @(negedge clk) begin
        if (!s_clrn) begin
            m_wait = 0; m_nd = 1'b1; m_pe = 1'b0; m_pb = 1'b0;
            m_valid = 1'b0; m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_rep = 1'b0;
            m_held = 1'b0; m_hcode = 8'h00; m_hext = 1'b0; m_cnt = '0; m_ovf = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (s_ovf) m_ovf = 1'b1;
            if (m_wait == 0 && s_ready) begin
                m_nd   = 1'b0;
                m_wait = 2;
                model_byte(s_data);
            end else begin
                m_nd = 1'b1;
                if (m_wait != 0) m_wait--;
            end
        end
        chk("nextdata_n", 32'(nextdata_n), 32'(m_nd));
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_code", 32'(key_code), 32'(m_code));
        chk("key_ext", 32'(key_ext), 32'(m_ext));
        chk("key_break", 32'(key_break), 32'(m_brk));
        chk("key_repeat", 32'(key_repeat), 32'(m_rep));
        chk("held", 32'(held), 32'(m_held));
        chk("held_code", 32'(held_code), 32'(m_hcode));
        chk("held_ext", 32'(held_ext), 32'(m_hext));
        chk("press_count", 32'(press_count), 32'(m_cnt));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        if (key_valid === 1'b1 && n_ev < 512) begin
            ev_code[n_ev]  = key_code;
            ev_ext[n_ev]   = key_ext;
            ev_brk[n_ev]   = key_break;
            ev_rep[n_ev]   = key_repeat;
            ev_hcode[n_ev] = held_code;
            ev_held[n_ev]  = held;
            ev_cnt[n_ev]   = press_count;
            n_ev++;
        end
        if (nextdata_n === 1'b0) begin
            n_ack++;
            if (fifo.size() != 0) void'(fifo.pop_front());
            fifo_sync();
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(logic [7:0] b);
        fifo.push_back(b);
        fifo_sync();
    endtask

    task automatic start_test();
        fifo.delete();
        fifo_sync();
        clrn = 1'b0;
        cyc(2);
        clrn = 1'b1;
        n_ev  = 0;
        n_ack = 0;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 3000 && fifo.size() != 0; i++) cyc(1);
        chk({name, "_drained"}, 32'(fifo.size()), 32'd0);
        cyc(4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk("reset_nextdata_n", 32'(nextdata_n), 32'd1);
        chk("reset_press_count", 32'(press_count), 32'd0);
        chk("reset_held", 32'(held), 32'd0);

        // Make then break of 1C
        start_test();
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain("t1");
        chk("t1_events", 32'(n_ev), 32'd2);
        chk("t1_make_code", 32'(ev_code[0]), 32'h1C);
        chk("t1_make_cnt", 32'(ev_cnt[0]), 32'd1);
        chk("t1_make_held", 32'(ev_held[0]), 32'd1);
        chk("t1_brk_flag", 32'(ev_brk[1]), 32'd1);
        chk("t1_brk_held", 32'(ev_held[1]), 32'd0);
        chk("t1_acks", 32'(n_ack), 32'd3);

        // Typematic repeats
        start_test();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        drain("t2");
        chk("t2_events", 32'(n_ev), 32'd4);
        chk("t2_rep0", 32'(ev_rep[0]), 32'd0);
        chk("t2_rep1", 32'(ev_rep[1]), 32'd1);
        chk("t2_rep2", 32'(ev_rep[2]), 32'd1);
        chk("t2_rep3", 32'(ev_rep[3]), 32'd0);
        chk("t2_count", 32'(press_count), 32'd1);

        // Extended make and break
        start_test();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain("t3");
        chk("t3_events", 32'(n_ev), 32'd2);
        chk("t3_ext0", 32'(ev_ext[0]), 32'd1);
        chk("t3_ext1", 32'(ev_ext[1]), 32'd1);
        chk("t3_code0", 32'(ev_code[0]), 32'h75);
        chk("t3_code1", 32'(ev_code[1]), 32'h75);
        chk("t3_brk1", 32'(ev_brk[1]), 32'd1);
        chk("t3_held", 32'(held), 32'd0);

        // Rollover and unmatched break
        start_test();
        push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
        drain("t4");
        chk("t4_events", 32'(n_ev), 32'd3);
        chk("t4_hcode1", 32'(ev_hcode[1]), 32'h32);
        chk("t4_brk2", 32'(ev_brk[2]), 32'd1);
        chk("t4_held", 32'(held), 32'd1);
        chk("t4_held_code", 32'(held_code), 32'h32);
        chk("t4_count", 32'(press_count), 32'd2);

        // Reset discards a pending E0 F0 prefix
        start_test();
        push(8'hE0); push(8'hF0);
        drain("t5a");
        clrn = 1'b0;
        cyc(1);
        clrn = 1'b1;
        push(8'h75);
        drain("t5b");
        chk("t5_events", 32'(n_ev), 32'd1);
        chk("t5_ext", 32'(ev_ext[0]), 32'd0);
        chk("t5_brk", 32'(ev_brk[0]), 32'd0);
        chk("t5_count", 32'(press_count), 32'd1);

        // Reset landing while the pop strobe is low
        start_test();
        push(8'h1C);
        cyc(1);
        chk("t6_ack_low", 32'(nextdata_n), 32'd0);
        clrn = 1'b0;
        cyc(1);
        chk("t6_ack_released", 32'(nextdata_n), 32'd1);
        clrn = 1'b1;
        cyc(4);

        // Press counter wrap
        start_test();
        for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
        drain("t7");
        chk("t7_events", 32'(n_ev), 32'd256);
        chk("t7_count_wrap", 32'(press_count), 32'd0);
        chk("t7_held_code", 32'(held_code), 32'h32);

        // Overflow is sticky and parsing continues; drop-list bytes are ignored
        start_test();
        overflow = 1'b1;
        cyc(1);
        overflow = 1'b0;
        push(8'hAA); push(8'hFA); push(8'h1C);
        drain("t8");
        chk("t8_ovf_set", 32'(ovf_err), 32'd1);
        chk("t8_events", 32'(n_ev), 32'd1);
        chk("t8_code", 32'(ev_code[0]), 32'h1C);
        start_test();
        cyc(1);
        chk("t8_ovf_cleared", 32'(ovf_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
